// File: rtl/axi_slave_package.sv
// Shared AXI write-path types and FIFO entry widths for the push and pop sides.
package axi_slave_package;

    localparam int unsigned AXI_ID_WIDTH    = 10;
    localparam int unsigned AXI_ADDR_WIDTH  = 64;
    localparam int unsigned AXI_LEN_WIDTH   = 8;
    localparam int unsigned AXI_DATA_WIDTH  = 128;
    localparam int unsigned AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8;
    localparam int unsigned AXI_USER_WIDTH  = 3;
    localparam int unsigned AXI_SIZE_WIDTH  = 3;
    localparam int unsigned AXI_BURST_WIDTH = 2;

    localparam int unsigned AW_FIFO_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + AXI_LEN_WIDTH
                                          + AXI_SIZE_WIDTH + AXI_BURST_WIDTH + AXI_USER_WIDTH;
    localparam int unsigned W_FIFO_WIDTH  = AXI_STRB_WIDTH + AXI_DATA_WIDTH;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_DATA  = 2'd1,
        WR_PAD   = 2'd2,
        WR_DRAIN = 2'd3
    } request_push_fsm_wr_state;

endpackage

// File: rtl/axi_wr_beat_counter.sv
// Remaining-beat counter for the write burst in flight: load, saturating decrement, zero flag.
module axi_wr_beat_counter
    import axi_slave_package::*;
#(
    parameter int unsigned LEN_WIDTH = AXI_LEN_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [LEN_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [LEN_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - LEN_WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fifo_push_wr.sv
// AXI4 write-request ingress: pushes AW entries and exactly AWLEN+1 W entries per burst,
// padding short bursts, draining long ones and flagging WLAST violations.
module fifo_push_wr
    import axi_slave_package::*;
#(
    parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH,
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = AXI_USER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  ARESTn,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [LEN_WIDTH-1:0]  AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [USER_WIDTH-1:0] AWUSER,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  aw_fifo_full,
    output logic                  aw_fifo_wr_en,
    output logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+3+2+USER_WIDTH-1:0] aw_fifo_wr_data,
    input  logic                  w_fifo_full,
    output logic                  w_fifo_wr_en,
    output logic [STRB_WIDTH+DATA_WIDTH-1:0] w_fifo_wr_data,
    output logic                  wr_err_valid,
    output logic [ID_WIDTH-1:0]   wr_err_id
);

    request_push_fsm_wr_state r_state;
    request_push_fsm_wr_state w_state_nxt;
    logic [ID_WIDTH-1:0]      r_aw_id;
    logic                     w_cnt_load;
    logic                     w_cnt_dec;
    logic                     w_cnt_zero;

    axi_wr_beat_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_cnt (
        .i_clk      (CLK),
        .i_rst_n    (ARESTn),
        .i_load     (w_cnt_load),
        .i_load_val (AWLEN),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!ARESTn) begin
            r_state <= WR_IDLE;
            r_aw_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (aw_fifo_wr_en) begin
                r_aw_id <= AWID;
            end
        end
    end

    // Next state, handshakes and FIFO pushes; everything is quiet while reset is held.
    always_comb begin
        w_state_nxt    = r_state;
        AWREADY        = 1'b0;
        WREADY         = 1'b0;
        aw_fifo_wr_en  = 1'b0;
        w_fifo_wr_en   = 1'b0;
        w_fifo_wr_data = '0;
        wr_err_valid   = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        unique case (r_state)
            WR_IDLE: begin
                AWREADY = !aw_fifo_full;
                if (AWVALID && !aw_fifo_full) begin
                    aw_fifo_wr_en = 1'b1;
                    w_cnt_load    = 1'b1;
                    w_state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                WREADY = !w_fifo_full;
                if (WVALID && !w_fifo_full) begin
                    w_fifo_wr_en   = 1'b1;
                    w_fifo_wr_data = {WSTRB, WDATA};
                    if (w_cnt_zero) begin
                        if (WLAST) begin
                            w_state_nxt = WR_IDLE;
                        end else begin
                            wr_err_valid = 1'b1;
                            w_state_nxt  = WR_DRAIN;
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                        if (WLAST) begin
                            wr_err_valid = 1'b1;
                            w_state_nxt  = WR_PAD;
                        end
                    end
                end
            end
            WR_PAD: begin
                if (!w_fifo_full) begin
                    w_fifo_wr_en = 1'b1;
                    if (w_cnt_zero) begin
                        w_state_nxt = WR_IDLE;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            WR_DRAIN: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) begin
                    w_state_nxt = WR_IDLE;
                end
            end
            default: w_state_nxt = WR_IDLE;
        endcase
        if (!ARESTn) begin
            w_state_nxt   = WR_IDLE;
            AWREADY       = 1'b0;
            WREADY        = 1'b0;
            aw_fifo_wr_en = 1'b0;
            w_fifo_wr_en  = 1'b0;
            wr_err_valid  = 1'b0;
            w_cnt_load    = 1'b0;
            w_cnt_dec     = 1'b0;
        end
    end

    assign aw_fifo_wr_data = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER};
    assign wr_err_id       = r_aw_id;

endmodule

// File: tb/tb_fifo_push_wr.sv
// Bench for fifo_push_wr: directed framing cases plus randomized bursts against a queue model.
module tb_fifo_push_wr;

    logic          CLK;
    logic          ARESTn;
    logic [9:0]    AWID;
    logic [63:0]   AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic [2:0]    AWUSER;
    logic          AWVALID;
    logic          AWREADY;
    logic [127:0]  WDATA;
    logic [15:0]   WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic          aw_fifo_full;
    logic          aw_fifo_wr_en;
    logic [89:0]   aw_fifo_wr_data;
    logic          w_fifo_full;
    logic          w_fifo_wr_en;
    logic [143:0]  w_fifo_wr_data;
    logic          wr_err_valid;
    logic [9:0]    wr_err_id;

    fifo_push_wr dut (
        .CLK             (CLK),
        .ARESTn          (ARESTn),
        .AWID            (AWID),
        .AWADDR          (AWADDR),
        .AWLEN           (AWLEN),
        .AWSIZE          (AWSIZE),
        .AWBURST         (AWBURST),
        .AWUSER          (AWUSER),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .WDATA           (WDATA),
        .WSTRB           (WSTRB),
        .WLAST           (WLAST),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .aw_fifo_full    (aw_fifo_full),
        .aw_fifo_wr_en   (aw_fifo_wr_en),
        .aw_fifo_wr_data (aw_fifo_wr_data),
        .w_fifo_full     (w_fifo_full),
        .w_fifo_wr_en    (w_fifo_wr_en),
        .w_fifo_wr_data  (w_fifo_wr_data),
        .wr_err_valid    (wr_err_valid),
        .wr_err_id       (wr_err_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int n_aw_push = 0;
    int n_w_push  = 0;
    int n_fill    = 0;
    int n_err     = 0;
    logic [9:0]   last_err_id = '0;
    logic [89:0]  last_aw = '0;

    logic [89:0]  exp_aw[$];
    logic [143:0] exp_w[$];
    logic         drv_err_exp = 1'b0;
    logic [9:0]   drv_id = '0;
    bit           rnd_full = 1'b0;
    int           stall_cnt = 0;

    task automatic check(input logic ok, input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An error is due on the WLAST beat of a short burst, or on beat AWLEN of a long one.
    function automatic logic err_at(input int b, input int k, input int len);
        return ((k < len + 1) && (b == k - 1)) || ((k > len + 1) && (b == len));
    endfunction

    task automatic tick();
        @(negedge CLK);
        if (rnd_full) begin
            aw_fifo_full = ($urandom_range(0, 3) == 0);
            w_fifo_full  = ($urandom_range(0, 3) == 0);
        end else begin
            aw_fifo_full = 1'b0;
            w_fifo_full  = (stall_cnt > 0);
            if (stall_cnt > 0) stall_cnt--;
        end
    endtask

    // Compare process: every accepted push is checked against the model queues.
    always @(negedge CLK) begin
        logic [89:0]  ea;
        logic [143:0] ew;
        #2;
        if (!ARESTn) begin
            check({AWREADY, WREADY, aw_fifo_wr_en, w_fifo_wr_en, wr_err_valid} == 5'b0,
                  "reset_outputs", 144'({AWREADY, WREADY, aw_fifo_wr_en, w_fifo_wr_en, wr_err_valid}), 144'(0));
        end else begin
            check(aw_fifo_wr_en == (AWVALID && AWREADY), "aw_push_on_hs", 144'(aw_fifo_wr_en), 144'(AWVALID && AWREADY));
            if (aw_fifo_wr_en) begin
                check(exp_aw.size() != 0, "aw_unexpected_push", aw_fifo_wr_data, 144'(0));
                if (exp_aw.size() != 0) begin
                    ea = exp_aw.pop_front();
                    check(aw_fifo_wr_data == ea, "aw_entry", 144'(aw_fifo_wr_data), 144'(ea));
                end
                n_aw_push++;
                last_aw = aw_fifo_wr_data;
            end
            if (w_fifo_wr_en) begin
                check(exp_w.size() != 0, "w_unexpected_push", w_fifo_wr_data, 144'(0));
                if (exp_w.size() != 0) begin
                    ew = exp_w.pop_front();
                    check(w_fifo_wr_data == ew, "w_entry", w_fifo_wr_data, ew);
                end
                n_w_push++;
                if (w_fifo_wr_data == '0) n_fill++;
            end
            check(!(w_fifo_full && w_fifo_wr_en), "w_push_while_full", 144'(w_fifo_wr_en), 144'(0));
            check(!(aw_fifo_full && AWREADY), "awready_while_full", 144'(AWREADY), 144'(0));
            check(!(AWREADY && WREADY), "aw_w_ready_exclusive", 144'({AWREADY, WREADY}), 144'(0));
            if (WVALID && WREADY) begin
                check(wr_err_valid == drv_err_exp, "err_pulse", 144'(wr_err_valid), 144'(drv_err_exp));
                if (drv_err_exp) begin
                    check(wr_err_id == drv_id, "err_id", 144'(wr_err_id), 144'(drv_id));
                    n_err++;
                    last_err_id = wr_err_id;
                end
            end else begin
                check(wr_err_valid == 1'b0, "err_spurious", 144'(wr_err_valid), 144'(0));
            end
        end
    end

    task automatic run_burst(input logic [9:0] id, input logic [63:0] addr, input int len, input int k,
                             input logic [2:0] size, input logic [1:0] burst, input logic [2:0] user,
                             input bit w_early, input int abort_at, input int stall_beat, input bit gaps);
        logic [143:0] beats[$];
        int to;
        for (int b = 0; b < k; b++)
            beats.push_back({16'($urandom) | 16'h1, $urandom, $urandom, $urandom, $urandom});
        exp_aw.push_back({id, addr, 8'(len), size, burst, user});
        for (int b = 0; b < k && b < len + 1; b++) exp_w.push_back(beats[b]);
        for (int b = k; b < len + 1; b++) exp_w.push_back('0);

        tick();
        if (gaps) while ($urandom_range(0, 3) == 0) tick();
        drv_id  = id;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = 8'(len);
        AWSIZE  = size;
        AWBURST = burst;
        AWUSER  = user;
        AWVALID = 1'b1;
        if (w_early) begin
            WVALID = 1'b1;
            {WSTRB, WDATA} = beats[0];
            WLAST = (k == 1);
            drv_err_exp = err_at(0, k, len);
        end
        #3;
        to = 0;
        while (!(AWVALID && AWREADY) && to < 500) begin
            tick();
            to++;
            #3;
        end
        check(to < 500, "aw_accept_timeout", 144'(to), 144'(500));
        if (w_early) check(WREADY == 1'b0, "w_blocked_in_idle", 144'(WREADY), 144'(0));

        for (int b = 0; b < k; b++) begin
            if (stall_beat == b) stall_cnt = 2;
            tick();
            AWVALID = 1'b0;
            if (!(w_early && b == 0)) begin
                if (gaps) begin
                    while ($urandom_range(0, 3) == 0) begin
                        WVALID = 1'b0;
                        drv_err_exp = 1'b0;
                        tick();
                    end
                end
                WVALID = 1'b1;
                {WSTRB, WDATA} = beats[b];
                WLAST = (b == k - 1);
                drv_err_exp = err_at(b, k, len);
            end
            if (abort_at == b) begin
                ARESTn = 1'b0;
                exp_w.delete();
                drv_err_exp = 1'b0;
                #3;
                tick();
                ARESTn = 1'b1;
                WVALID = 1'b0;
                WLAST  = 1'b0;
                #3;
                check(wr_err_id == 10'h0, "rst_err_id", 144'(wr_err_id), 144'(0));
                check(AWREADY == 1'b1, "rst_back_idle", 144'(AWREADY), 144'(1));
                return;
            end
            #3;
            if (w_early && b == 0) check(WREADY == 1'b1, "w_early_next_cycle", 144'(WREADY), 144'(1));
            to = 0;
            while (!(WVALID && WREADY) && to < 500) begin
                if (stall_beat == b && w_fifo_full)
                    check(WREADY == 1'b0, "stall_wready_low", 144'(WREADY), 144'(0));
                tick();
                to++;
                #3;
            end
            check(to < 500, "w_accept_timeout", 144'(to), 144'(500));
        end
        tick();
        WVALID = 1'b0;
        WLAST  = 1'b0;
        drv_err_exp = 1'b0;
        #3;
    endtask

    task automatic drain();
        int to = 0;
        while (exp_w.size() != 0 && to < 200) begin
            tick();
            to++;
            #3;
        end
        check(exp_w.size() == 0, "drain_pending_w", 144'(exp_w.size()), 144'(0));
    endtask

    initial begin
        int a0, w0, f0, e0, len, k, r;
        ARESTn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWUSER = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        aw_fifo_full = 1'b0; w_fifo_full = 1'b0;
        repeat (3) tick();
        tick();
        ARESTn = 1'b1;
        #3;
        check(AWREADY == 1'b1, "idle_awready", 144'(AWREADY), 144'(1));
        check(WREADY == 1'b0, "idle_wready", 144'(WREADY), 144'(0));
        check(wr_err_id == 10'h0, "reset_err_id", 144'(wr_err_id), 144'(0));

        // Single-beat burst, id 5
        a0 = n_aw_push; w0 = n_w_push; f0 = n_fill; e0 = n_err;
        run_burst(10'h5, 64'h1000, 0, 1, 3'd4, 2'd1, 3'd2, 1'b0, -1, -1, 1'b0);
        check(AWREADY == 1'b1, "single_idle_next", 144'(AWREADY), 144'(1));
        check(last_aw == {10'h005, 64'h0000_0000_0000_1000, 8'h00, 3'd4, 2'd1, 3'd2},
              "single_aw_literal", 144'(last_aw), 144'({10'h005, 64'h1000, 8'h00, 3'd4, 2'd1, 3'd2}));
        check(n_aw_push - a0 == 1, "single_aw_cnt", 144'(n_aw_push - a0), 144'(1));
        check(n_w_push - w0 == 1, "single_w_cnt", 144'(n_w_push - w0), 144'(1));
        check(n_err - e0 == 0, "single_err_cnt", 144'(n_err - e0), 144'(0));

        // Four beats with a two-cycle full stall on beat 2
        w0 = n_w_push; e0 = n_err;
        run_burst(10'h11, 64'h2000, 3, 4, 3'd4, 2'd1, 3'd0, 1'b0, -1, 1, 1'b0);
        drain();
        check(n_w_push - w0 == 4, "stall_w_cnt", 144'(n_w_push - w0), 144'(4));
        check(n_err - e0 == 0, "stall_err_cnt", 144'(n_err - e0), 144'(0));

        // Early WLAST: two real beats, two fillers
        w0 = n_w_push; f0 = n_fill; e0 = n_err;
        run_burst(10'h2A, 64'h3000, 3, 2, 3'd4, 2'd1, 3'd1, 1'b0, -1, -1, 1'b0);
        drain();
        check(n_w_push - w0 == 4, "pad_w_cnt", 144'(n_w_push - w0), 144'(4));
        check(n_fill - f0 == 2, "pad_fill_cnt", 144'(n_fill - f0), 144'(2));
        check(n_err - e0 == 1, "pad_err_cnt", 144'(n_err - e0), 144'(1));
        check(last_err_id == 10'h2A, "pad_err_id", 144'(last_err_id), 144'(10'h2A));

        // Late WLAST: two pushes, beats 3-4 drained
        w0 = n_w_push; f0 = n_fill; e0 = n_err;
        run_burst(10'h3C1, 64'h4000, 1, 4, 3'd4, 2'd1, 3'd3, 1'b0, -1, -1, 1'b0);
        drain();
        check(n_w_push - w0 == 2, "drain_w_cnt", 144'(n_w_push - w0), 144'(2));
        check(n_fill - f0 == 0, "drain_fill_cnt", 144'(n_fill - f0), 144'(0));
        check(n_err - e0 == 1, "drain_err_cnt", 144'(n_err - e0), 144'(1));
        check(last_err_id == 10'h3C1, "drain_err_id", 144'(last_err_id), 144'(10'h3C1));

        // AW and W valid together in idle
        w0 = n_w_push;
        run_burst(10'h77, 64'h5000, 2, 3, 3'd4, 2'd1, 3'd4, 1'b1, -1, -1, 1'b0);
        drain();
        check(n_w_push - w0 == 3, "early_w_cnt", 144'(n_w_push - w0), 144'(3));

        // Reset during beat 2 of an eight-beat burst, then a normal burst
        a0 = n_aw_push; w0 = n_w_push;
        run_burst(10'h99, 64'h6000, 7, 8, 3'd4, 2'd1, 3'd5, 1'b0, 1, -1, 1'b0);
        check(n_aw_push - a0 == 1, "rst_aw_cnt", 144'(n_aw_push - a0), 144'(1));
        check(n_w_push - w0 == 1, "rst_w_cnt", 144'(n_w_push - w0), 144'(1));
        a0 = n_aw_push; w0 = n_w_push;
        run_burst(10'h123, 64'h7000, 1, 2, 3'd4, 2'd1, 3'd6, 1'b0, -1, -1, 1'b0);
        drain();
        check(n_aw_push - a0 == 1, "post_rst_aw_cnt", 144'(n_aw_push - a0), 144'(1));
        check(n_w_push - w0 == 2, "post_rst_w_cnt", 144'(n_w_push - w0), 144'(2));

        // Randomized bursts with random full flags and valid gaps
        rnd_full = 1'b1;
        for (int i = 0; i < 150; i++) begin
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (r < 7) k = len + 1;
            else if (r < 8 && len > 0) k = int'($urandom_range(1, len));
            else k = len + 1 + int'($urandom_range(1, 3));
            run_burst(10'($urandom), {$urandom, $urandom}, len, k, 3'($urandom), 2'($urandom),
                      3'($urandom), 1'b0, -1, -1, 1'b1);
        end
        rnd_full = 1'b0;
        drain();
        check(exp_aw.size() == 0, "final_aw_pending", 144'(exp_aw.size()), 144'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
